// File: rtl/pipe_stage_chain.sv
// Multi-stage pipeline register chain with a valid bit per stage, flush, and bubble collapse under stall.
// Empty stages always carry data=0 and ctrl=CTRL_BUBBLE so downstream side effects stay disabled.
module pipe_stage_chain #(
    parameter int                 DATA_W      = 16,
    parameter int                 CTRL_W      = 8,
    parameter int                 STAGES      = 2,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    input  logic [CTRL_W-1:0]             in_ctrl,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    output logic [CTRL_W-1:0]             out_ctrl,
    output logic [$clog2(STAGES+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] valid_q, valid_d;
    logic [DATA_W-1:0] data_q [STAGES];
    logic [DATA_W-1:0] data_d [STAGES];
    logic [CTRL_W-1:0] ctrl_q [STAGES];
    logic [CTRL_W-1:0] ctrl_d [STAGES];
    logic [OCC_W-1:0]  occ_q, occ_d;

    logic [STAGES-1:0] en;
    logic [STAGES-1:0] src_valid;
    logic [DATA_W-1:0] src_data [STAGES];
    logic [CTRL_W-1:0] src_ctrl [STAGES];

    // A stage may advance when any stage at or beyond it is empty, or the head is released.
    always_comb begin : advance_enable
        logic hole;
        en   = '0;
        hole = ~stall;
        for (int k = STAGES - 1; k >= 0; k--) begin
            hole  = hole | ~valid_q[k];
            en[k] = hole;
        end
    end

    assign in_ready = en[0];

    always_comb begin : source_select
        src_valid    = '0;
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        src_ctrl[0]  = in_ctrl;
        for (int k = 1; k < STAGES; k++) begin
            src_valid[k] = valid_q[k-1];
            src_data[k]  = data_q[k-1];
            src_ctrl[k]  = ctrl_q[k-1];
        end
    end

    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    always_comb begin : next_state
        valid_d = valid_q;
        occ_d   = '0;
        for (int k = 0; k < STAGES; k++) begin
            data_d[k] = data_q[k];
            ctrl_d[k] = ctrl_q[k];
            if (flush) begin
                valid_d[k] = 1'b0;
                data_d[k]  = '0;
                ctrl_d[k]  = CTRL_BUBBLE;
            end else if (en[k]) begin
                valid_d[k] = src_valid[k];
                data_d[k]  = src_valid[k] ? src_data[k] : '0;
                ctrl_d[k]  = src_valid[k] ? src_ctrl[k] : CTRL_BUBBLE;
            end
        end
        for (int k = 0; k < STAGES; k++) begin
            occ_d = occ_d + OCC_W'(valid_d[k]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    // NOTE: the payload array is reset too, because empty stages must present data=0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
                ctrl_q[k] <= CTRL_BUBBLE;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
                ctrl_q[k] <= ctrl_d[k];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign out_ctrl  = ctrl_q[STAGES-1];
    assign occupancy = occ_q;

endmodule
